// File: rtl/switch_debounce_ctrl.sv
// Two-flop synchronizer plus debounce FSM for a bouncing slide switch; emits a clean level,
// one-cycle rise/fall strobes and the PWM enable. Define SWITCH_TOGGLE_MODE_EN for toggle enable.
//
// state     | meaning
// ----------+-------------------------------------------------------
// STABLE_LO | accepted level is 0, waiting for sync_q to go high
// CHECK_HI  | sync_q high, counting stable cycles before accepting 1
// STABLE_HI | accepted level is 1, waiting for sync_q to go low
// CHECK_LO  | sync_q low, counting stable cycles before accepting 0
module switch_debounce_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic sysclk,
  input  logic sysrst,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_enable
);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] CHECK_HI  = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] CHECK_LO  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             sync_q, sync_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    s1_d    = sw_raw;
    sync_d  = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync_q) begin
          state_d = CHECK_HI;
          cnt_d   = '0;
        end
      end
      CHECK_HI: begin
        if (!sync_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync_q) begin
          state_d = CHECK_LO;
          cnt_d   = '0;
        end
      end
      CHECK_LO: begin
        if (sync_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sysrst) begin
      s1_q    <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

`ifdef SWITCH_TOGGLE_MODE_EN
  // Flips on the edge that samples the rise strobe, so a push button latches the PWM on/off.
  logic enable_q, enable_d;

  always_comb begin
    enable_d = enable_q ^ rise_q;
  end

  always_ff @(posedge sysclk) begin
    if (sysrst) enable_q <= 1'b0;
    else        enable_q <= enable_d;
  end

  assign sw_enable = enable_q;
`else
  assign sw_enable = level_q;
`endif

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Bench for switch_debounce_ctrl: run-length reference model compared every cycle,
// directed scenarios with literal timing expectations, then randomized bursts.
module tb_switch_debounce_ctrl;

  localparam int D  = 4;
  localparam int CW = 3;

  logic sysclk, sysrst, sw_raw;
  logic sw_level, sw_rise, sw_fall, sw_enable;

  int n_vec = 0;
  int n_err = 0;

  switch_debounce_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .sysclk(sysclk), .sysrst(sysrst), .sw_raw(sw_raw),
    .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_enable(sw_enable)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a 2-deep history of raw samples, and a run length of samples
  // disagreeing with the accepted level; D+1 consecutive disagreements flip it.
  bit m_h0, m_h1, m_level, m_rise, m_fall, m_en, m_valid;
  int m_run;
  bit samp;

  always @(posedge sysclk) begin
    if (sysrst) begin
      m_h0 = 0; m_h1 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_en = 0; m_run = 0;
    end else begin
      samp = m_h1;
      m_h1 = m_h0;
      m_h0 = sw_raw;
`ifdef SWITCH_TOGGLE_MODE_EN
      if (m_rise) m_en = ~m_en;
`endif
      m_rise = 0;
      m_fall = 0;
      if (samp != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = samp;
          m_run   = 0;
          if (samp) m_rise = 1; else m_fall = 1;
        end
      end else begin
        m_run = 0;
      end
`ifndef SWITCH_TOGGLE_MODE_EN
      m_en = m_level;
`endif
    end
    m_valid = 1;
  end

  always @(negedge sysclk) begin
    if (m_valid) begin
      chk("model_level",  sw_level,  m_level);
      chk("model_rise",   sw_rise,   m_rise);
      chk("model_fall",   sw_fall,   m_fall);
      chk("model_enable", sw_enable, m_en);
      chk("rise_fall_exclusive", sw_rise & sw_fall, 0);
    end
  end

  task automatic tick();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic wait_strobe(input bit want_rise, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (want_rise ? sw_rise : sw_fall) return;
    end
    chk(want_rise ? "timeout_rise" : "timeout_fall", 0, 1);
  endtask

  int n, cnt;
  bit val;
  int len;
  logic [1:0] exp_en;

  initial begin
    m_valid = 0;
    sysrst  = 1'b1;
    sw_raw  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_level", sw_level, 0);
      chk("reset_rise", sw_rise, 0);
      chk("reset_enable", sw_enable, 0);
    end
    // Switch high out of reset: first free edge is edge 0, acceptance on edge D+2.
    sysrst = 1'b0;
    for (int i = 0; i < D + 2; i++) tick();
    chk("post_reset_early_level", sw_level, 0);
    tick();
    chk("post_reset_level", sw_level, 1);
    chk("post_reset_rise", sw_rise, 1);
    tick();
    chk("post_reset_rise_drop", sw_rise, 0);

    sw_raw = 1'b0;
    for (int i = 0; i < D + 2; i++) tick();
    chk("fall_early_level", sw_level, 1);
    tick();
    chk("fall_level", sw_level, 0);
    chk("fall_strobe", sw_fall, 1);
    tick();
    chk("fall_strobe_drop", sw_fall, 0);

    sw_raw = 1'b1;
    cnt = 0;
    for (int i = 0; i < D + 2; i++) begin tick(); cnt += sw_fall; end
    chk("rise_early_level", sw_level, 0);
    tick();
    chk("rise_level", sw_level, 1);
    chk("rise_strobe", sw_rise, 1);
    tick();
    chk("rise_strobe_drop", sw_rise, 0);
    chk("rise_no_fall", cnt, 0);

    // Short low glitch from the high level must be absorbed.
    sw_raw = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin tick(); cnt += sw_fall; end
    sw_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin tick(); cnt += sw_fall; end
    chk("glitch_level", sw_level, 1);
    chk("glitch_no_fall", cnt, 0);

    sw_raw = 1'b0;
    wait_strobe(0, n);
    chk("fall2_latency", n, D + 3);
    for (int i = 0; i < 3; i++) tick();

    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      sw_raw = (i % 2 == 0);
      tick();
      cnt += sw_rise;
    end
    sw_raw = 1'b1;
    wait_strobe(1, n);
    chk("bounce_latency", n, D + 3);
    cnt += sw_rise;
    for (int i = 0; i < 12; i++) begin tick(); cnt += sw_rise; end
    chk("bounce_single_rise", cnt, 1);

    // Press/release cycles for the enable output.
    sysrst = 1'b1;
    sw_raw = 1'b0;
    tick(); tick();
    chk("enable_reset", sw_enable, 0);
    sysrst = 1'b0;
    tick(); tick();
    for (int p = 0; p < 3; p++) begin
      sw_raw = 1'b1;
      wait_strobe(1, n);
      tick();
`ifdef SWITCH_TOGGLE_MODE_EN
      exp_en = (p % 2 == 0) ? 2'd1 : 2'd0;
`else
      exp_en = 2'd1;
`endif
      chk("enable_after_rise", sw_enable, exp_en);
      sw_raw = 1'b0;
      wait_strobe(0, n);
      tick();
`ifndef SWITCH_TOGGLE_MODE_EN
      exp_en = 2'd0;
`endif
      chk("enable_after_fall", sw_enable, exp_en);
    end
    sysrst = 1'b1;
    tick();
    chk("enable_reset_again", sw_enable, 0);
    sysrst = 1'b0;

    for (int b = 0; b < 300; b++) begin
      if ($urandom_range(0, 30) == 0) begin
        sysrst = 1'b1;
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) tick();
        sysrst = 1'b0;
      end
      val = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      sw_raw = val;
      for (int i = 0; i < len; i++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
